// File: rtl/boot_pkg.sv
// Shared types and constants for the warm-boot reboot sequencer.
// Holds the FSM encoding, image selectors and the request arbiter.
package boot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DETACH = 2'd1,
    ST_FIRE   = 2'd2
  } state_e;

  localparam logic [1:0] IMG_SPRINGBOARD = 2'd0;
  localparam logic [1:0] IMG_DFU         = 2'd1;
  localparam logic [1:0] IMG_USER        = 2'd2;
  localparam logic [1:0] IMG_INVALID     = 2'd3;

  // Returns {valid, image}; DFU_DETACH beats software requests, which beat the button.
  function automatic logic [2:0] arbitrate(input logic       dfu,
                                           input logic       req,
                                           input logic [1:0] img,
                                           input logic       lp);
    logic [2:0] res;
    if (dfu) begin
      res = {1'b1, IMG_DFU};
    end else if (req && (img != IMG_INVALID)) begin
      res = {1'b1, img};
    end else if (lp) begin
      res = {1'b1, IMG_DFU};
    end else begin
      res = 3'b000;
    end
    return res;
  endfunction

endpackage

// File: rtl/button_longpress.sv
// Push-button front end: two-flop synchronizer, debounce and long-press detect.
// Emits a single-cycle request once per debounced press held long enough.
module button_longpress #(
  parameter int DEBOUNCE_CYCLES  = 4800,
  parameter int LONGPRESS_CYCLES = 96000000,
  parameter int CW               = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic i_button,
  output logic o_press_req
);
  import boot_pkg::*;

  logic          sync1_q;
  logic          sync2_q;
  logic [1:0]    vld_q;
  logic          db_q;
  logic [CW-1:0] db_cnt_q;
  logic [CW-1:0] lp_cnt_q;
  logic          fired_q;
  logic          armed_q;
  logic          req_q;

  // Arming needs a genuine released sample, so a button held through reset stays inert.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      vld_q    <= 2'b00;
      db_q     <= 1'b0;
      db_cnt_q <= '0;
      lp_cnt_q <= '0;
      fired_q  <= 1'b0;
      armed_q  <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      sync1_q <= i_button;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      req_q   <= 1'b0;

      if (sync2_q != db_q) begin
        if (db_cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          db_q     <= sync2_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_q <= '0;
      end

      if (vld_q[1] && !sync2_q && !db_q) begin
        armed_q <= 1'b1;
      end

      if (db_q && armed_q) begin
        if (!fired_q) begin
          if (lp_cnt_q == CW'(LONGPRESS_CYCLES - 1)) begin
            req_q    <= 1'b1;
            fired_q  <= 1'b1;
            lp_cnt_q <= '0;
          end else begin
            lp_cnt_q <= lp_cnt_q + 1'b1;
          end
        end
      end else begin
        lp_cnt_q <= '0;
        fired_q  <= 1'b0;
      end
    end
  end

  assign o_press_req = req_q;

endmodule

// File: rtl/reboot_sequencer.sv
// Reboot sequencer: arbitrates reboot sources, detaches USB, then fires warm boot.
// o_mode/o_boot feed the warm-boot primitive wrapper directly.
module reboot_sequencer #(
  parameter int DETACH_CYCLES    = 48000,
  parameter int DEBOUNCE_CYCLES  = 4800,
  parameter int LONGPRESS_CYCLES = 96000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic [1:0] i_req_image,
  input  logic       i_dfu_detach,
  input  logic       i_button,
  output logic [1:0] o_mode,
  output logic       o_boot,
  output logic       o_usb_pullup_en,
  output logic       o_busy
);
  import boot_pkg::*;

  localparam int MAX_AB = (DETACH_CYCLES > DEBOUNCE_CYCLES) ? DETACH_CYCLES : DEBOUNCE_CYCLES;
  localparam int MAX_P  = (MAX_AB > LONGPRESS_CYCLES) ? MAX_AB : LONGPRESS_CYCLES;
  localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    mode_q;
  logic          boot_q;
  logic          pullup_q;
  logic          busy_q;
  logic          lp_req_s;
  logic [2:0]    sel_s;

  button_longpress #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .LONGPRESS_CYCLES(LONGPRESS_CYCLES),
    .CW              (CW)
  ) u_button (
    .clk        (clk),
    .rst        (rst),
    .i_button   (i_button),
    .o_press_req(lp_req_s)
  );

  assign sel_s = arbitrate(i_dfu_detach, i_req, i_req_image, lp_req_s);

  // Sequencer FSM; once out of IDLE every request is ignored until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mode_q   <= IMG_USER;
      boot_q   <= 1'b0;
      pullup_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_s[2]) begin
            state_q  <= ST_DETACH;
            mode_q   <= sel_s[1:0];
            cnt_q    <= CW'(DETACH_CYCLES - 1);
            pullup_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        ST_DETACH: begin
          if (cnt_q == '0) begin
            state_q <= ST_FIRE;
            boot_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_FIRE: begin
          boot_q   <= 1'b1;
          pullup_q <= 1'b0;
          busy_q   <= 1'b1;
        end
        default: begin
          state_q  <= ST_IDLE;
          cnt_q    <= '0;
          mode_q   <= IMG_USER;
          boot_q   <= 1'b0;
          pullup_q <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_mode          = mode_q;
  assign o_boot          = boot_q;
  assign o_usb_pullup_en = pullup_q;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_reboot_sequencer.sv
// Self-checking bench for reboot_sequencer: history-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_reboot_sequencer;
  localparam int DET = 10;
  localparam int DEB = 4;
  localparam int LP  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_req;
  logic [1:0] i_req_image;
  logic       i_dfu_detach;
  logic       i_button;
  logic [1:0] o_mode;
  logic       o_boot;
  logic       o_usb_pullup_en;
  logic       o_busy;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int         k;
  logic       bh[$];
  logic       sh[$];
  logic       ph[$];
  logic       mdb, marmed, mfired, lp_pend, act;
  int         m_start;
  logic [1:0] m_img;
  logic [1:0] e_mode;
  logic       e_boot, e_pull, e_busy;
  logic       btn_lvl;

  reboot_sequencer #(
    .DETACH_CYCLES   (DET),
    .DEBOUNCE_CYCLES (DEB),
    .LONGPRESS_CYCLES(LP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req          (i_req),
    .i_req_image    (i_req_image),
    .i_dfu_detach   (i_dfu_detach),
    .i_button       (i_button),
    .o_mode         (o_mode),
    .o_boot         (o_boot),
    .o_usb_pullup_en(o_usb_pullup_en),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act_v, input logic [7:0] exp_v);
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act_v, exp_v);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_edge(input logic r, input logic rq, input logic [1:0] im,
                            input logic df, input logic bt);
    logic samp, flag, pulse, all_ok, arm_now;
    if (r) begin
      k = 0;
      bh.delete(); sh.delete(); ph.delete();
      mdb = 1'b0; marmed = 1'b0; mfired = 1'b0; lp_pend = 1'b0; act = 1'b0;
      m_start = 0; m_img = 2'd2;
    end else begin
      k++;
      samp = (k >= 3) ? bh[k-3] : 1'b0;
      bh.push_back(bt);
      flag = mdb && marmed;
      ph.push_back(flag);
      pulse = 1'b0;
      if (!flag) begin
        mfired = 1'b0;
      end else if (!mfired && k >= LP) begin
        all_ok = 1'b1;
        for (int i = k - LP; i < k; i++) if (!ph[i]) all_ok = 1'b0;
        if (all_ok) begin
          pulse = 1'b1;
          mfired = 1'b1;
        end
      end
      if (!act) begin
        if (df) begin
          act = 1'b1; m_img = 2'd1; m_start = k;
        end else if (rq && im != 2'd3) begin
          act = 1'b1; m_img = im; m_start = k;
        end else if (lp_pend) begin
          act = 1'b1; m_img = 2'd1; m_start = k;
        end
      end
      lp_pend = pulse;
      arm_now = (k >= 3) && !samp && !mdb;
      sh.push_back(samp);
      if (k >= DEB) begin
        all_ok = 1'b1;
        for (int i = k - DEB; i < k; i++) if (sh[i] == mdb) all_ok = 1'b0;
        if (all_ok) mdb = !mdb;
      end
      if (arm_now) marmed = 1'b1;
    end
    if (act) begin
      e_mode = m_img; e_pull = 1'b0; e_busy = 1'b1; e_boot = ((k - m_start) >= DET);
    end else begin
      e_mode = 2'd2; e_pull = 1'b1; e_busy = 1'b0; e_boot = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic rq, input logic [1:0] im,
                      input logic df, input logic bt);
    rst = r; i_req = rq; i_req_image = im; i_dfu_detach = df; i_button = bt;
    @(posedge clk);
    model_edge(r, rq, im, df, bt);
    #1;
    chk("mode",   {6'd0, o_mode},          {6'd0, e_mode});
    chk("boot",   {7'd0, o_boot},          {7'd0, e_boot});
    chk("pullup", {7'd0, o_usb_pullup_en}, {7'd0, e_pull});
    chk("busy",   {7'd0, o_busy},          {7'd0, e_busy});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 1'b0, btn_lvl);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'd0, 1'b0, btn_lvl);
  endtask

  initial begin
    btn_lvl = 1'b0;
    do_reset(3);
    chk("rst_mode", {6'd0, o_mode}, 8'd2);
    chk("rst_pullup", {7'd0, o_usb_pullup_en}, 8'd1);
    chk("rst_busy", {7'd0, o_busy}, 8'd0);

    // software request, image 2, boot 11 edges after the strobe
    idle(1);
    step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    chk("req_mode", {6'd0, o_mode}, 8'd2);
    chk("req_pullup", {7'd0, o_usb_pullup_en}, 8'd0);
    for (int i = 0; i < 9; i++) begin
      idle(1);
      chk("req_boot_early", {7'd0, o_boot}, 8'd0);
    end
    idle(1);
    chk("req_boot_edge11", {7'd0, o_boot}, 8'd1);
    idle(3);
    chk("req_boot_held", {7'd0, o_boot}, 8'd1);
    chk("req_mode_held", {6'd0, o_mode}, 8'd2);

    // simultaneous dfu_detach and req(image 0)
    do_reset(2);
    step(1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
    chk("prio_mode", {6'd0, o_mode}, 8'd1);
    idle(12);

    // first accepted target wins
    do_reset(2);
    step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("first_wins_mode", {6'd0, o_mode}, 8'd2);
    idle(10);

    // invalid image discarded
    do_reset(2);
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    chk("img3_busy", {7'd0, o_busy}, 8'd0);
    chk("img3_mode", {6'd0, o_mode}, 8'd2);
    idle(3);

    // reset mid-DETACH aborts, fresh request completes
    do_reset(2);
    step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    idle(5);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("abort_pullup", {7'd0, o_usb_pullup_en}, 8'd1);
    chk("abort_busy", {7'd0, o_busy}, 8'd0);
    chk("abort_boot", {7'd0, o_boot}, 8'd0);
    idle(1);
    step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    idle(10);
    chk("after_abort_boot", {7'd0, o_boot}, 8'd1);
    chk("after_abort_mode", {6'd0, o_mode}, 8'd1);

    // glitch ignored, long press reboots to DFU
    do_reset(2);
    idle(6);
    btn_lvl = 1'b1; idle(3);
    btn_lvl = 1'b0; idle(40);
    chk("glitch_busy", {7'd0, o_busy}, 8'd0);
    btn_lvl = 1'b1; idle(30);
    btn_lvl = 1'b0; idle(25);
    chk("lp_busy", {7'd0, o_busy}, 8'd1);
    chk("lp_mode", {6'd0, o_mode}, 8'd1);
    chk("lp_boot", {7'd0, o_boot}, 8'd1);

    // button held through reset must be released first
    btn_lvl = 1'b1;
    do_reset(2);
    idle(40);
    chk("held_busy", {7'd0, o_busy}, 8'd0);
    btn_lvl = 1'b0; idle(20);
    btn_lvl = 1'b1; idle(30);
    btn_lvl = 1'b0; idle(25);
    chk("repress_busy", {7'd0, o_busy}, 8'd1);

    // randomized traffic
    for (int round = 0; round < 24; round++) begin
      int run;
      logic quiet;
      quiet = (round % 3 == 0);
      btn_lvl = 1'b0;
      run = 0;
      do_reset(2);
      for (int c = 0; c < 250; c++) begin
        logic r, rq, df;
        logic [1:0] im;
        if (run == 0) begin
          btn_lvl = ($urandom_range(0, 1) == 1);
          run = $urandom_range(1, 35);
        end
        run--;
        r  = ($urandom_range(0, 199) == 0);
        rq = !quiet && ($urandom_range(0, 14) == 0);
        df = !quiet && ($urandom_range(0, 29) == 0);
        im = 2'($urandom_range(0, 3));
        step(r, rq, im, df, btn_lvl);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reboot_sequencer.md
REBOOT_SEQUENCER -- requirements
Module: reboot_sequencer

Interface
REQ-001 Parameter DETACH_CYCLES, default 48000, cycles the USB pull-up is held off before the warm boot fires.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4800, cycles the button must be stable before a level change is accepted.
REQ-003 Parameter LONGPRESS_CYCLES, default 96000000, cycles a debounced press must last to request the DFU bootloader.
REQ-004 Port: clk  input  1  system clock; the single clock of the block.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: i_req  input  1  one-cycle software reboot request strobe.
REQ-007 Port: i_req_image  input  2  target image for i_req (0 springboard, 1 DFU bootloader, 2 user application).
REQ-008 Port: i_dfu_detach  input  1  one-cycle DFU_DETACH strobe from the USB stack; targets image 1.
REQ-009 Port: i_button  input  1  raw, asynchronous push-button, active-high.
REQ-010 Port: o_mode  output  2  image select driven to the warm-boot primitive wrapper.
REQ-011 Port: o_boot  output  1  warm-boot trigger driven to the warm-boot primitive wrapper.
REQ-012 Port: o_usb_pullup_en  output  1  USB D+ pull-up enable; low means detached.
REQ-013 Port: o_busy  output  1  high while a reboot is in progress.

Function
REQ-014 The button SHALL pass through a two-flop synchronizer before any other use.
REQ-015 A synchronized level change SHALL be accepted after DEBOUNCE_CYCLES consecutive equal samples; shorter glitches SHALL be ignored.
REQ-016 A debounced press held for LONGPRESS_CYCLES SHALL raise one internal request for image 1; it SHALL fire once per press.
REQ-017 States SHALL be IDLE, DETACH and FIRE.
REQ-018 In IDLE: o_boot=0, o_busy=0, o_usb_pullup_en=1, o_mode=2'd2.
REQ-019 Source priority, highest first: i_dfu_detach, then i_req, then long-press.
REQ-020 An i_req with i_req_image=3 SHALL be discarded; the state stays IDLE.
REQ-021 On an accepted request in IDLE, the block SHALL latch the target into o_mode on the next edge.
REQ-022 On that same edge it SHALL enter DETACH, load the counter with DETACH_CYCLES-1, and drive o_usb_pullup_en=0 and o_busy=1.
REQ-023 DETACH SHALL decrement the counter each cycle.
REQ-024 When the counter is 0, DETACH SHALL go to FIRE on the next edge, after exactly DETACH_CYCLES cycles in DETACH.
REQ-025 FIRE is terminal: o_boot=1 and o_usb_pullup_en=0 held until reset, o_mode unchanged.
REQ-026 Requests arriving in DETACH or FIRE SHALL be ignored; the first accepted target wins.
REQ-027 o_mode SHALL be stable from one cycle before o_boot rises and for as long as o_boot is high.
REQ-028 All outputs SHALL be registered.
REQ-029 A counter width of clog2 of the largest parameter SHALL be used; no counter may wrap.

Reset
REQ-030 On rst: state IDLE, counters 0, debounced button 0, long-press flag cleared, and outputs at their IDLE values.
REQ-031 rst asserted in DETACH or FIRE SHALL abort the reboot and return to IDLE values on the next edge.
REQ-032 A button held through reset SHALL NOT trigger until it is released and pressed again.

Structure
REQ-033 The state encoding and image constants IMG_SPRINGBOARD=0, IMG_DFU=1, IMG_USER=2 SHALL live in the shared package boot_pkg.
REQ-034 Synchronizer, debounce and long-press logic SHALL form one sub-module, button_longpress, with a one-cycle press-request output.
REQ-035 reboot_sequencer SHALL drive the existing warm-boot wrapper directly: o_mode to its mode input, o_boot to its boot input.

Verification
REQ-036 Scenario: i_req=1 with i_req_image=2 for one cycle, DETACH_CYCLES=10 -> o_mode=2 and o_usb_pullup_en=0 next edge; o_boot=1 exactly 11 edges after the strobe, then held.
REQ-037 Scenario: i_dfu_detach and i_req(image 0) in the same cycle -> o_mode=1.
REQ-038 Scenario: i_req(image 2), then i_dfu_detach 3 cycles later -> o_mode stays 2.
REQ-039 Scenario: i_req_image=3 strobe -> o_busy remains 0 and all outputs unchanged.
REQ-040 Scenario: DEBOUNCE_CYCLES=4, LONGPRESS_CYCLES=20; 3-cycle glitch -> no action; 30-cycle press -> one reboot to image 1.
REQ-041 Scenario: rst pulsed 5 cycles into DETACH -> o_usb_pullup_en=1, o_busy=0, o_boot=0 next edge; a fresh i_req then completes normally.
